// File: rtl/sram_pkg.sv
// sram_pkg: shared types and parameter decoding for the behavioural SRAM models.
package sram_pkg;
  typedef enum logic [1:0] {RDW_DONT_CARE, RDW_OLD_DATA, RDW_NEW_DATA} rdw_mode_t;
  function automatic rdw_mode_t rdw_mode(input string s);
    return s == "NEW_DATA" ? RDW_NEW_DATA : s == "OLD_DATA" ? RDW_OLD_DATA : RDW_DONT_CARE;
  endfunction
  function automatic bit rdw_legal(input string s);
    return s == "DONT_CARE" || s == "OLD_DATA" || s == "NEW_DATA";
  endfunction
endpackage

// File: rtl/sram_valid_bits.sv
// sram_valid_bits: per-word valid flags, cleared asynchronously, set on write.
module sram_valid_bits #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic [AW-1:0] set_addr,
  input  logic [AW-1:0] addr,
  output logic          hit
);
  logic [2**AW-1:0] valid;
  always_ff @(posedge clk or negedge reset)
    if (!reset) valid <= '0;
    else if (set) valid[set_addr] <= 1'b1;
  assign hit = valid[addr];
endmodule

// File: rtl/altsyncram_dp.sv
// altsyncram_dp: simple dual-port block RAM (write port A, read port B) with
// asynchronous whole-array clear implemented through per-word valid bits.
module altsyncram_dp
  import sram_pkg::*;
#(
  parameter string OPERATION_MODE                = "DUAL_PORT",
  parameter int    WIDTH_A                       = 32,
  parameter int    WIDTHAD_A                     = 10,
  parameter int    WIDTH_B                       = 32,
  parameter int    WIDTHAD_B                     = 10,
  parameter string READ_DURING_WRITE_MIXED_PORTS = "DONT_CARE"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wren_a,
  input  logic [WIDTHAD_A-1:0] address_a,
  input  logic [WIDTH_A-1:0]   data_a,
  output logic [WIDTH_A-1:0]   q_a,
  input  logic                 rden_b,
  input  logic [WIDTHAD_B-1:0] address_b,
  output logic [WIDTH_B-1:0]   q_b
);
  localparam rdw_mode_t RDW = rdw_mode(READ_DURING_WRITE_MIXED_PORTS);
  if (OPERATION_MODE != "DUAL_PORT") begin : g_bad_mode
    $error("altsyncram_dp: OPERATION_MODE must be DUAL_PORT");
  end
  if (WIDTH_A != WIDTH_B || WIDTHAD_A != WIDTHAD_B) begin : g_bad_width
    $error("altsyncram_dp: port A and port B geometry must match");
  end
  if (!rdw_legal(READ_DURING_WRITE_MIXED_PORTS)) begin : g_bad_rdw
    $error("altsyncram_dp: illegal READ_DURING_WRITE_MIXED_PORTS");
  end
  // No reset on the array so it maps to block RAM; a write during reset
  // lands here but its valid bit stays clear, so it is never observed.
  logic [WIDTH_A-1:0] mem [2**WIDTHAD_A];
  logic               hit;
  logic               collide;
  always_ff @(posedge clk)
    if (wren_a) mem[address_a] <= data_a;
  sram_valid_bits #(.AW(WIDTHAD_A)) u_valid (
    .clk      (clk),
    .reset    (reset),
    .set      (wren_a),
    .set_addr (address_a),
    .addr     (address_b),
    .hit      (hit)
  );
  assign collide = wren_a && address_a == address_b;
  assign q_a     = '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) q_b <= '0;
    else if (rden_b) q_b <= (RDW == RDW_NEW_DATA && collide) ? data_a : hit ? mem[address_b] : '0;
  a_known_wr: assert property (@(posedge clk) disable iff (!reset) !$isunknown({wren_a, address_a}));
endmodule

// File: tb/tb_altsyncram_dp.sv
// tb_altsyncram_dp: directed and randomized checks of altsyncram_dp against an array model.
module tb_altsyncram_dp;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wren_a = 1'b0;
  logic [9:0]  address_a = '0;
  logic [31:0] data_a = '0;
  logic [31:0] q_a;
  logic        rden_b = 1'b0;
  logic [9:0]  address_b = '0;
  logic [31:0] q_b;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mdl [1024];
  logic [31:0] exp_q = '0;

  altsyncram_dp dut (
    .clk       (clk),
    .reset     (reset),
    .wren_a    (wren_a),
    .address_a (address_a),
    .data_a    (data_a),
    .q_a       (q_a),
    .rden_b    (rden_b),
    .address_b (address_b),
    .q_b       (q_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    exp_q = '0;
  endtask

  // Reads see the array as it was before this edge's write (DONT_CARE build = old data).
  task automatic cycle(input logic we, input logic [9:0] wa, input logic [31:0] wd,
                       input logic re, input logic [9:0] ra, input string tag);
    wren_a = we; address_a = wa; data_a = wd; rden_b = re; address_b = ra;
    @(posedge clk);
    #1;
    if (re) exp_q = mdl[ra];
    if (we) mdl[wa] = wd;
    wren_a = 1'b0; rden_b = 1'b0;
    check(tag, q_b, exp_q);
  endtask

  initial begin
    model_clear();
    #2 check("reset_q_b_async", q_b, 32'h0);
    repeat (2) @(posedge clk);
    #4 reset = 1'b1;
    @(negedge clk);
    check("reset_q_a", q_a, 32'h0);
    cycle(0, 0, 0, 1, 10'd5, "read_unwritten_5");
    check("read_unwritten_5_lit", q_b, 32'h0);
    cycle(1, 10'd3, 32'hDEADBEEF, 0, 0, "write_3");
    cycle(0, 0, 0, 1, 10'd3, "read_3");
    check("read_3_lit", q_b, 32'hDEADBEEF);
    cycle(0, 0, 0, 1, 10'd3, "reread_3");
    cycle(1, 10'd3, 32'h1, 0, 10'd3, "hold_1");
    cycle(1, 10'd3, 32'h1, 0, 10'd3, "hold_2");
    check("hold_lit", q_b, 32'hDEADBEEF);
    cycle(1, 10'd7, 32'hAA, 0, 0, "write_7_old");
    cycle(1, 10'd7, 32'h12345678, 1, 10'd7, "rdw_7");
    check("rdw_7_lit", q_b, 32'hAA);
    cycle(0, 0, 0, 1, 10'd7, "read_7_after");
    check("read_7_after_lit", q_b, 32'h12345678);
    cycle(1, 10'd9, 32'hCAFE, 1, 10'd9, "rdw_never_written");
    check("rdw_never_written_lit", q_b, 32'h0);
    cycle(1, 10'd0, 32'h55, 0, 0, "write_0");
    cycle(1, 10'd1023, 32'h55, 0, 0, "write_1023");
    cycle(0, 0, 0, 1, 10'd1023, "read_1023");
    check("read_1023_lit", q_b, 32'h55);
    #3 reset = 1'b0;
    #1 check("mid_cycle_reset_q_b", q_b, 32'h0);
    model_clear();
    wren_a = 1'b1; address_a = 10'd0; data_a = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 wren_a = 1'b0;
    check("write_during_reset_q_b", q_b, 32'h0);
    #3 reset = 1'b1;
    @(negedge clk);
    cycle(0, 0, 0, 1, 10'd0, "post_reset_0");
    check("post_reset_0_lit", q_b, 32'h0);
    cycle(0, 0, 0, 1, 10'd1023, "post_reset_1023");
    check("post_reset_1023_lit", q_b, 32'h0);
    for (int i = 0; i < 10000; i++) begin
      logic [9:0] wa, ra;
      wa = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
      cycle(1'($urandom), wa, $urandom, 1'($urandom), ra, "random");
      check("q_a_zero", q_a, 32'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
